// File: rtl/fpumuld_retire.sv
// Retire buffer behind the double/extended FP multiplier: result FIFO, writeback handshake, sticky FP flags.
// Optional same-cycle bypass when empty: define FPUMULD_RETIRE_BYPASS_EN.
module fpumuld_retire #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned TAG_W     = 9,
   parameter int unsigned AF_MARGIN = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_en,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [67:0]      in_res,
   input  logic [15:0]      in_res_hi,
   input  logic [10:0]      in_raise,
   input  logic             flush,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [TAG_W-1:0] out_tag,
   output logic [67:0]      out_res,
   output logic [15:0]      out_res_hi,
   output logic [10:0]      out_raise,
   output logic             almost_full,
   input  logic [10:0]      excpt_mask,
   input  logic             flags_clr,
   output logic [10:0]      flags_sticky,
   output logic             excpt_pend,
   output logic             ovf_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [67:0]      res;
      logic [15:0]      res_hi;
      logic [10:0]      raise;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wp, rp, wp_n, rp_n;
   logic [CNT_W-1:0] count, count_n;
   logic             fifo_vld_c, full_c, byp_c, pop_c, rd_c, push_c, ovf_c;
   entry_t           in_entry_c, head_c;

   assign in_entry_c = '{tag: in_tag, res: in_res, res_hi: in_res_hi, raise: in_raise};
   assign fifo_vld_c = (count != '0);
   assign full_c     = (count == CNT_W'(DEPTH));

`ifdef FPUMULD_RETIRE_BYPASS_EN
   assign byp_c = ~fifo_vld_c & in_en & ~flush;
`else
   assign byp_c = 1'b0;
`endif

   // A bypassed result retired in its arrival cycle is never written, so rp must not move.
   assign out_vld = fifo_vld_c | byp_c;
   assign pop_c   = out_vld & out_rdy & ~flush;
   assign rd_c    = pop_c & fifo_vld_c;
   assign push_c  = in_en & ~flush & (~full_c | pop_c) & ~(byp_c & out_rdy);
   assign ovf_c   = in_en & ~flush & full_c & ~pop_c;

   // Head mux; fields read as zero whenever nothing is valid.
   always_comb begin
      head_c = '0;
      if (byp_c) begin
         head_c = in_entry_c;
      end else if (fifo_vld_c) begin
         head_c = mem[rp];
      end
   end

   assign out_tag    = head_c.tag;
   assign out_res    = head_c.res;
   assign out_res_hi = head_c.res_hi;
   assign out_raise  = head_c.raise;

   // Pointer and occupancy next state.
   always_comb begin
      wp_n    = wp;
      rp_n    = rp;
      count_n = count;
      if (flush) begin
         wp_n    = '0;
         rp_n    = '0;
         count_n = '0;
      end else begin
         if (push_c) wp_n = wp + PTR_W'(1);
         if (rd_c)   rp_n = rp + PTR_W'(1);
         if (push_c & ~rd_c) begin
            count_n = count + CNT_W'(1);
         end else if (~push_c & rd_c) begin
            count_n = count - CNT_W'(1);
         end
      end
   end

   // Storage needs no reset; empty reads are masked by head_c.
   always_ff @(posedge clk) begin
      if (push_c) mem[wp] <= in_entry_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp          <= '0;
         rp          <= '0;
         count       <= '0;
         almost_full <= 1'b0;
      end else begin
         wp          <= wp_n;
         rp          <= rp_n;
         count       <= count_n;
         almost_full <= ((32'(DEPTH) - 32'(count_n)) <= 32'(AF_MARGIN));
      end
   end

   // Sticky exception state; a pop in a clear cycle survives the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_sticky <= '0;
         excpt_pend   <= 1'b0;
         ovf_err      <= 1'b0;
      end else begin
         flags_sticky <= (flags_clr ? 11'd0 : flags_sticky) | (pop_c ? head_c.raise : 11'd0);
         excpt_pend   <= (flags_clr ? 1'b0 : excpt_pend) | (pop_c & (|(head_c.raise & excpt_mask)));
         if (ovf_c) ovf_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fpumuld_retire.sv
// Scoreboard bench for fpumuld_retire: reference queue model checked every negedge plus directed checks.
module tb_fpumuld_retire;

   localparam int unsigned DEPTH     = 4;
   localparam int unsigned AF_MARGIN = 2;
   localparam int          INV_BIT   = 4;

   typedef struct packed {
      logic [8:0]  tag;
      logic [67:0] res;
      logic [15:0] hi;
      logic [10:0] raise;
   } ent_t;

   logic        clk, rst;
   logic        in_en, flush, out_rdy, flags_clr;
   logic [8:0]  in_tag, out_tag;
   logic [67:0] in_res, out_res;
   logic [15:0] in_res_hi, out_res_hi;
   logic [10:0] in_raise, out_raise, excpt_mask, flags_sticky;
   logic        out_vld, almost_full, excpt_pend, ovf_err;

   int total = 0;
   int bad   = 0;

   ent_t        q[$];
   logic [10:0] m_flags;
   logic        m_pend, m_ovf;

   fpumuld_retire #(.DEPTH(DEPTH), .TAG_W(9), .AF_MARGIN(AF_MARGIN)) dut (
      .clk(clk), .rst(rst), .in_en(in_en), .in_tag(in_tag), .in_res(in_res),
      .in_res_hi(in_res_hi), .in_raise(in_raise), .flush(flush), .out_vld(out_vld),
      .out_rdy(out_rdy), .out_tag(out_tag), .out_res(out_res), .out_res_hi(out_res_hi),
      .out_raise(out_raise), .almost_full(almost_full), .excpt_mask(excpt_mask),
      .flags_clr(flags_clr), .flags_sticky(flags_sticky), .excpt_pend(excpt_pend),
      .ovf_err(ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_flags = '0;
      m_pend  = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic cyc(input logic en, input logic [8:0] tag, input logic [67:0] res,
                      input logic [15:0] hi, input logic [10:0] rs, input logic rdy,
                      input logic fl, input logic clr);
      in_en = en; in_tag = tag; in_res = res; in_res_hi = hi; in_raise = rs;
      out_rdy = rdy; flush = fl; flags_clr = clr;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, 9'd0, 68'd0, 16'd0, 11'd0, rdy, 1'b0, 1'b0);
   endtask

   // Reference model: check outputs against current model state, then advance it with this cycle's inputs.
   always @(negedge clk) begin : mon
      ent_t head;
      logic byp, mv, pop, was_full, push;
      if (!rst) begin
         byp = 1'b0;
`ifdef FPUMULD_RETIRE_BYPASS_EN
         byp = (q.size() == 0) && in_en && !flush;
`endif
         mv   = (q.size() != 0) || byp;
         head = byp ? ent_t'{in_tag, in_res, in_res_hi, in_raise} : ((q.size() != 0) ? q[0] : '0);
         chk("vld", out_vld, mv);
         chk("head", {out_tag, out_res, out_res_hi, out_raise}, mv ? head : '0);
         chk("af", almost_full, (DEPTH - q.size()) <= AF_MARGIN);
         chk("flags", flags_sticky, m_flags);
         chk("pend", excpt_pend, m_pend);
         chk("ovf", ovf_err, m_ovf);
         pop      = mv && out_rdy && !flush;
         was_full = (q.size() == DEPTH);
         push     = in_en && !flush && (!was_full || pop) && !(byp && pop);
         if (in_en && !flush && was_full && !pop) m_ovf = 1'b1;
         m_flags = (flags_clr ? 11'd0 : m_flags) | (pop ? head.raise : 11'd0);
         m_pend  = (flags_clr ? 1'b0 : m_pend) | (pop && ((head.raise & excpt_mask) != 0));
         if (flush) q.delete();
         else begin
            if (pop && !byp) void'(q.pop_front());
            if (push) q.push_back(ent_t'{in_tag, in_res, in_res_hi, in_raise});
         end
      end
   end

   initial begin
      rst = 1'b1;
      excpt_mask = '0;
      model_clear();
      cyc(1'b0, 9'd0, 68'd0, 16'd0, 11'd0, 1'b0, 1'b0, 1'b0);
      chk("rst_vld", out_vld, 1'b0);
      chk("rst_outs", {out_tag, out_res, out_res_hi, out_raise}, '0);
      chk("rst_af", almost_full, 1'b0);
      rst = 1'b0;

      // Single result through with writeback ready.
      cyc(1'b1, 9'h05, 68'h1_4000_0000_0000_0000, 16'h3fff, 11'd0, 1'b1, 1'b0, 1'b0);
      idle(3, 1'b1);

      // Full FIFO, then simultaneous push and pop.
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 9'(6 + i), {4'h2, 64'(i) * 64'h1111}, 16'(i), 11'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 9'd10, 68'hA_0000_0000_0000_00AA, 16'h00aa, 11'd0, 1'b1, 1'b0, 1'b0);
      chk("pp_vld", out_vld, 1'b1);
      chk("pp_af", almost_full, 1'b1);
      chk("pp_ovf", ovf_err, 1'b0);
      idle(6, 1'b1);

      // Five pushes into four entries with writeback stalled.
      for (int i = 1; i <= 5; i++) begin
         cyc(1'b1, 9'(i), {4'h3, 64'(i)}, 16'(i), 11'd0, 1'b0, 1'b0, 1'b0);
         if (i == 1) chk("af_1", almost_full, 1'b0);
         if (i == 2) chk("af_2", almost_full, 1'b1);
         if (i == 4) chk("ovf_4", ovf_err, 1'b0);
         if (i == 5) chk("ovf_5", ovf_err, 1'b1);
      end
      idle(6, 1'b1);
      chk("drain_vld", out_vld, 1'b0);

      // Invalid-op retire in the same cycle as a clear.
      excpt_mask = 11'(1 << INV_BIT);
      cyc(1'b1, 9'h20, 68'h0_0000_0000_0000_0001, 16'h0, 11'(1 << INV_BIT), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 9'h0, 68'h0, 16'h0, 11'd0, 1'b1, 1'b0, 1'b1);
      chk("inv_flag", flags_sticky[INV_BIT], 1'b1);
      chk("inv_pend", excpt_pend, 1'b1);
      cyc(1'b0, 9'h0, 68'h0, 16'h0, 11'd0, 1'b1, 1'b0, 1'b1);
      chk("clr_flags", flags_sticky, 11'd0);
      chk("clr_pend", excpt_pend, 1'b0);

      // Flush with a push and a ready writeback in the same cycle.
      cyc(1'b1, 9'h31, 68'h0_0000_0000_0000_0031, 16'h1, 11'h7ff, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 9'h32, 68'h0_0000_0000_0000_0032, 16'h2, 11'h7ff, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 9'h33, 68'h0_0000_0000_0000_0033, 16'h3, 11'h7ff, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 9'h34, 68'h0_0000_0000_0000_0034, 16'h4, 11'h7ff, 1'b1, 1'b1, 1'b0);
      chk("fl_vld", out_vld, 1'b0);
      chk("fl_flags", flags_sticky, 11'd0);
      chk("fl_af", almost_full, 1'b0);
      idle(2, 1'b1);

      // Randomised traffic against the model.
      for (int i = 0; i < 300; i++) begin
         excpt_mask = 11'($urandom);
         cyc(($urandom_range(0, 2) != 0), 9'($urandom), {4'($urandom), $urandom, $urandom},
             16'($urandom), ($urandom_range(0, 3) == 0) ? 11'(1 << $urandom_range(0, 10)) : 11'd0,
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0));
      end
      idle(6, 1'b1);

      // Asynchronous reset with two entries buffered.
      cyc(1'b1, 9'h41, 68'h0_0000_0000_0000_0041, 16'h41, 11'h001, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 9'h42, 68'h0_0000_0000_0000_0042, 16'h42, 11'h002, 1'b0, 1'b0, 1'b0);
      in_en = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("arst_vld", out_vld, 1'b0);
      chk("arst_outs", {out_tag, out_res, out_res_hi, out_raise}, '0);
      chk("arst_flags", {flags_sticky, excpt_pend, ovf_err, almost_full}, '0);
      model_clear();
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(1'b1, 9'h50, 68'h0_0000_0000_0000_0050, 16'h50, 11'd0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_vld", out_vld, 1'b1);
      idle(3, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
